// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the external SRAM controller: FSM state encodings,
// the default CPU base address of the SRAM window, SRAM data width and the
// wait counter width. Imported by sram_ctrl and sram_wait_counter.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
    localparam int          SRAM_DW           = 16;
    // Wide enough for the largest legal WAIT_CYCLES-1 (14).
    localparam int          WAIT_W            = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Phase timer: loads WAIT_CYCLES-1 on phase entry, counts down to zero, and
// holds there; last=1 while the count is zero (final cycle of a phase).
// Ports: clk, rst (sync, active-high), load (phase entry), last (final phase cycle).
module sram_wait_counter
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= WAIT_W'(WAIT_CYCLES - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - WAIT_W'(1);
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage to 16-bit SRAM sequencer: each 32-bit access is split into a low
// and a high half-word phase of WAIT_CYCLES clocks each; ready=0 stalls the
// pipeline until the DONE cycle. Optional macro SRAM_CTRL_ERR_EN adds the
// addr_err output and short-circuits out-of-window requests straight to DONE.
// Ports: clk/rst; CPU side wr_en, rd_en, address, write_data, read_data, ready;
// SRAM side sram_addr, sram_dq_out, sram_dq_oe, sram_dq_in, sram_we_n.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          WAIT_CYCLES = 2,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n
`ifdef SRAM_CTRL_ERR_EN
    ,
    output logic               addr_err
`endif
);

    state_t             state, state_nxt;
    logic               req;
    logic [31:0]        offset;
    logic [SRAM_AW-2:0] widx_in;
    logic               bad_addr;
    logic               cnt_load;
    logic               last;
    logic               in_phase;

    logic               is_wr_q;
    logic [SRAM_AW-2:0] widx_q;
    logic [31:0]        wdata_q;

    assign req     = rd_en | wr_en;
    // Unsigned wrap below BASE_ADDR is intentional; only the low widx bits survive.
    assign offset  = address - BASE_ADDR;
    assign widx_in = offset[SRAM_AW:2];

`ifdef SRAM_CTRL_ERR_EN
    logic unused_bits;
    logic err_q;

    assign unused_bits = ^offset[1:0];
    // Below the window, or a word index that does not fit in SRAM_AW-1 bits.
    assign bad_addr    = (address < BASE_ADDR) | (|offset[31:SRAM_AW+1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == S_IDLE && req) begin
            err_q <= bad_addr;
        end
    end

    assign addr_err = (state == S_DONE) & err_q;
`else
    logic unused_bits;

    assign unused_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
    assign bad_addr    = 1'b0;
`endif

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (bad_addr) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_LO;
                        cnt_load  = 1'b1;
                    end
                end
            end
            S_LO: begin
                if (last) begin
                    state_nxt = S_HI;
                    cnt_load  = 1'b1;
                end
            end
            S_HI: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture and read-data assembly. A dropped request does not
    // abort the access because everything after IDLE uses the latched copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_wr_q   <= 1'b0;
            widx_q    <= '0;
            wdata_q   <= '0;
            read_data <= '0;
        end else begin
            if (state == S_IDLE && req) begin
                is_wr_q <= wr_en;   // write wins when both are asserted
                widx_q  <= widx_in;
                wdata_q <= write_data;
            end
            if (!is_wr_q && last) begin
                if (state == S_LO) begin
                    read_data[15:0] <= sram_dq_in;
                end
                if (state == S_HI) begin
                    read_data[31:16] <= sram_dq_in;
                end
            end
        end
    end

    // Pin outputs decode straight from the state register, so a synchronous
    // reset releases the strobe and the data bus on the very edge it is taken.
    assign in_phase    = (state == S_LO) | (state == S_HI);
    assign sram_addr   = {widx_q, (state == S_HI)};
    assign sram_dq_oe  = in_phase & is_wr_q;
    // The final cycle of a write phase keeps data/address stable with we_n high.
    assign sram_we_n   = ~(in_phase & is_wr_q & ~last);
    assign sram_dq_out = !sram_dq_oe        ? '0 :
                         (state == S_HI)    ? wdata_q[31:16] : wdata_q[15:0];
    assign ready       = ~req | (state == S_DONE);

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
`ifdef SRAM_CTRL_ERR_EN
    logic        addr_err;
`endif

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;
    int lows, wep, oep;

    logic [15:0] mem [0:262143];

    always #5 clk = ~clk;

    sram_ctrl #(
        .BASE_ADDR   (32'd1024),
        .WAIT_CYCLES (2),
        .SRAM_AW     (18)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
`ifdef SRAM_CTRL_ERR_EN
        ,
        .addr_err    (addr_err)
`endif
    );

    // Asynchronous-read SRAM model; writes land on clock edges with we_n low.
    assign sram_dq_in = mem[sram_addr];

    always @(posedge clk) begin
        if (!sram_we_n) begin
            mem[sram_addr] = sram_dq_out;
            strobes++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request at a negedge and follows it to the DONE cycle.
    // Returns the number of ready-low cycles, we_n-low cycles and oe-high cycles.
    // Leaves the request asserted, 1ns into the DONE cycle.
    task automatic do_access(input logic w, input logic r, input logic [31:0] a,
                             input logic [31:0] d, output int nlow, output int nwe,
                             output int noe);
        nlow = 0; nwe = 0; noe = 0;
        @(negedge clk);
        wr_en = w; rd_en = r; address = a; write_data = d;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (sram_we_n === 1'b0) nwe++;
            if (sram_dq_oe === 1'b1) noe++;
            if (ready === 1'b1) break;
            nlow++;
            @(negedge clk);
        end
    endtask

    task automatic drop_req();
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_read_data", read_data, 32'h0);
        check("rst_sram_addr", 32'(sram_addr), 32'h0);
        check("rst_dq_out", 32'(sram_dq_out), 32'h0);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
        check("rst_we_n", 32'(sram_we_n), 32'h1);
        check("rst_ready", 32'(ready), 32'h1);
        rst = 1'b0;

        // 1: store 0xDEADBEEF at 0x400
        do_access(1'b1, 1'b0, 32'h400, 32'hDEADBEEF, lows, wep, oep);
        check("t1_ready_low", lows, 5);
        check("t1_we_pulses", wep, 2);
        check("t1_oe_cycles", oep, 4);
        check("t1_mem0", 32'(mem[0]), 32'h0000BEEF);
        check("t1_mem1", 32'(mem[1]), 32'h0000DEAD);
        drop_req();
        @(negedge clk); #1;
        check("t1_idle_ready", 32'(ready), 32'h1);

        // 2: load at 0x404
        mem[2] = 16'h1234; mem[3] = 16'h5678;
        do_access(1'b0, 1'b1, 32'h404, 32'h0, lows, wep, oep);
        check("t2_ready_low", lows, 5);
        check("t2_read_data", read_data, 32'h56781234);
        check("t2_we_pulses", wep, 0);
        check("t2_oe_cycles", oep, 0);
        drop_req();

        // 3: back-to-back store then load at 0x408
        do_access(1'b1, 1'b0, 32'h408, 32'hCAFEF00D, lows, wep, oep);
        check("t3_st_we_pulses", wep, 2);
        do_access(1'b0, 1'b1, 32'h408, 32'h0, lows, wep, oep);
        check("t3_ld_ready_low", lows, 5);
        check("t3_ld_we_pulses", wep, 0);
        check("t3_read_data", read_data, 32'hCAFEF00D);
        check("t3_mem4", 32'(mem[4]), 32'h0000F00D);
        check("t3_mem5", 32'(mem[5]), 32'h0000CAFE);
        check("t3_total_strobes", strobes, 4);
        drop_req();

        // address[1:0] ignored
        do_access(1'b0, 1'b1, 32'h407, 32'h0, lows, wep, oep);
        check("align_read_data", read_data, 32'h56781234);
        drop_req();

        // 4: reset in the 2nd HI cycle of a store
        @(negedge clk);
        wr_en = 1'b1; address = 32'h40C; write_data = 32'h11112222;
        repeat (4) @(negedge clk);
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk); #1;
        check("t4_we_n", 32'(sram_we_n), 32'h1);
        check("t4_dq_oe", 32'(sram_dq_oe), 32'h0);
        check("t4_read_data", read_data, 32'h0);
        check("t4_ready", 32'(ready), 32'h1);
        check("t4_sram_addr", 32'(sram_addr), 32'h0);
        rst = 1'b0;

        // 5: wr_en and rd_en together -> write only
        do_access(1'b0, 1'b1, 32'h404, 32'h0, lows, wep, oep);
        check("t5_pre_read_data", read_data, 32'h56781234);
        drop_req();
        do_access(1'b1, 1'b1, 32'h410, 32'hA5A5A5A5, lows, wep, oep);
        check("t5_we_pulses", wep, 2);
        check("t5_read_data", read_data, 32'h56781234);
        check("t5_mem8", 32'(mem[8]), 32'h0000A5A5);
        check("t5_mem9", 32'(mem[9]), 32'h0000A5A5);
        drop_req();

`ifdef SRAM_CTRL_ERR_EN
        // 6: out-of-window load goes straight to DONE
        do_access(1'b0, 1'b1, 32'h3FC, 32'h0, lows, wep, oep);
        check("t6_ready_low", lows, 1);
        check("t6_addr_err", 32'(addr_err), 32'h1);
        check("t6_we_pulses", wep, 0);
        check("t6_oe_cycles", oep, 0);
        check("t6_read_data", read_data, 32'h56781234);
        drop_req();
        @(negedge clk); #1;
        check("t6_addr_err_clear", 32'(addr_err), 32'h0);
`else
        // Below-window address wraps to the top of the SRAM.
        mem[18'h3FFFE] = 16'h0BAD; mem[18'h3FFFF] = 16'hF00D;
        do_access(1'b0, 1'b1, 32'h3FC, 32'h0, lows, wep, oep);
        check("wrap_ready_low", lows, 5);
        check("wrap_read_data", read_data, 32'hF00D0BAD);
        drop_req();
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
